// File: rtl/sound_sequencer.sv
// Event-driven square-wave tone sequencer: pitch/duration per game event, fixed priority, mute.
// Optional amplitude decay is enabled by defining SOUND_ENVELOPE_EN.
module sound_sequencer #(
  parameter int               OUT_W    = 8,
  parameter int               DIV_W    = 16,
  parameter int               DUR_W    = 20,
  parameter logic [OUT_W-1:0] AMP      = 8'hC0,
  parameter logic [DIV_W-1:0] DIV_GOOD = 16'd40,
  parameter logic [DIV_W-1:0] DIV_BAD  = 16'd90,
  parameter logic [DIV_W-1:0] DIV_DIR  = 16'd20,
  parameter logic [DIV_W-1:0] DIR_STEP = 16'd4,
  parameter logic [DUR_W-1:0] DUR_GOOD = 20'd2000,
  parameter logic [DUR_W-1:0] DUR_BAD  = 20'd4000,
  parameter logic [DUR_W-1:0] DUR_DIR  = 20'd500,
  parameter logic [DIV_W-1:0] ENV_STEP = 16'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_i,
  input  logic             goodColl_i,
  input  logic             badColl_i,
  input  logic [3:0]       direction_i,
  output logic [OUT_W-1:0] soundOut,
  output logic             busy_o,
  output logic             muted_o
);

  // state  | meaning
  // S_IDLE | silent, waiting for an unmuted event
  // S_PLAY | tone running, duration counter active
  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t           state_q;
  logic             btn_q, good_q, bad_q, phase_q;
  logic [3:0]       dir_q;
  logic [1:0]       prio_q;
  logic [DIV_W-1:0] div_q, half_q;
  logic [DUR_W-1:0] dur_q;

  logic             btn_ev, ev_good, ev_bad, ev_dir, ev_any, mute_nx, take, advance;
  logic [1:0]       dir_idx, ev_prio;
  logic [DIV_W-1:0] ev_div;
  logic [DUR_W-1:0] ev_dur;
  logic [OUT_W-1:0] amp_nx;

  always_comb begin
    btn_ev  = button_i & ~btn_q;
    ev_good = goodColl_i & ~good_q;
    ev_bad  = badColl_i & ~bad_q;
    ev_dir  = $onehot(direction_i) && (direction_i != dir_q);
    dir_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (direction_i[i]) dir_idx = 2'(i);
    mute_nx = muted_o ^ btn_ev;
    ev_any  = ev_good | ev_bad | ev_dir;
    if (ev_bad) begin
      ev_prio = 2'd2;
      ev_div  = DIV_BAD;
      ev_dur  = DUR_BAD - 1'b1;
    end else if (ev_good) begin
      ev_prio = 2'd1;
      ev_div  = DIV_GOOD;
      ev_dur  = DUR_GOOD - 1'b1;
    end else begin
      ev_prio = 2'd0;
      ev_div  = DIV_DIR + DIV_W'(dir_idx) * DIR_STEP;
      ev_dur  = DUR_DIR - 1'b1;
    end
    // equal priority restarts the tone, lower priority is dropped
    take    = ev_any && !mute_nx && ((state_q == S_IDLE) || (ev_prio >= prio_q));
    advance = !mute_nx && !take && (state_q == S_PLAY) && (dur_q != '0);
  end

`ifdef SOUND_ENVELOPE_EN
  logic [OUT_W-1:0] amp_q;
  logic [DIV_W-1:0] env_q;

  always_comb begin
    amp_nx = amp_q;
    if (env_q == '0 && amp_q != '0) amp_nx = amp_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      amp_q <= '0;
      env_q <= '0;
    end else if (take) begin
      amp_q <= AMP;
      env_q <= ENV_STEP - 1'b1;
    end else if (advance) begin
      amp_q <= amp_nx;
      env_q <= (env_q == '0) ? ENV_STEP - 1'b1 : env_q - 1'b1;
    end
  end
`else
  assign amp_nx = AMP;
  wire unused_env = ^ENV_STEP;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      btn_q    <= 1'b0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      dir_q    <= 4'b0000;
      muted_o  <= 1'b0;
      busy_o   <= 1'b0;
      soundOut <= '0;
      phase_q  <= 1'b0;
      prio_q   <= 2'd0;
      div_q    <= '0;
      half_q   <= '0;
      dur_q    <= '0;
    end else begin
      btn_q   <= button_i;
      good_q  <= goodColl_i;
      bad_q   <= badColl_i;
      dir_q   <= direction_i;
      muted_o <= mute_nx;
      if (mute_nx) begin
        state_q  <= S_IDLE;
        busy_o   <= 1'b0;
        soundOut <= '0;
        phase_q  <= 1'b0;
      end else if (take) begin
        state_q  <= S_PLAY;
        busy_o   <= 1'b1;
        prio_q   <= ev_prio;
        div_q    <= ev_div;
        half_q   <= ev_div - 1'b1;
        dur_q    <= ev_dur;
        phase_q  <= 1'b1;
        soundOut <= AMP;
      end else if (state_q == S_PLAY) begin
        if (dur_q == '0) begin
          state_q  <= S_IDLE;
          busy_o   <= 1'b0;
          soundOut <= '0;
          phase_q  <= 1'b0;
        end else begin
          dur_q <= dur_q - 1'b1;
          if (half_q == '0) begin
            half_q   <= div_q - 1'b1;
            phase_q  <= ~phase_q;
            soundOut <= phase_q ? '0 : amp_nx;
          end else begin
            half_q   <= half_q - 1'b1;
            soundOut <= phase_q ? amp_nx : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: vector table, hand sequences, random run vs tone model.
// Honours SOUND_ENVELOPE_EN in its reference model.
module tb_sound_sequencer;
  localparam int ENV = 4;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1, button_i = 1'b0, goodColl_i = 1'b0, badColl_i = 1'b0;
  logic [3:0] direction_i = 4'b0000;
  logic [7:0] soundOut;
  logic       busy_o, muted_o;
  int         checks = 0, errors = 0;

  always #5 tb_clk = ~tb_clk;

  sound_sequencer #(
    .OUT_W(8), .DIV_W(16), .DUR_W(20), .AMP(8'hC0),
    .DIV_GOOD(16'd4), .DIV_BAD(16'd9), .DIV_DIR(16'd2), .DIR_STEP(16'd1),
    .DUR_GOOD(20'd20), .DUR_BAD(20'd40), .DUR_DIR(20'd10), .ENV_STEP(16'd4)
  ) dut (
    .clk(tb_clk), .rst(rst), .button_i(button_i), .goodColl_i(goodColl_i),
    .badColl_i(badColl_i), .direction_i(direction_i), .soundOut(soundOut),
    .busy_o(busy_o), .muted_o(muted_o)
  );

  // Reference: a tone is (priority, divisor, length) plus k = cycles since it started.
  bit       m_pb, m_pg, m_pbad, m_muted, m_active;
  bit [3:0] m_pd;
  int       m_prio, m_div, m_dur, m_k;

  task automatic model_step(input bit r, b, g, bd, input bit [3:0] d);
    bit e_btn, e_g, e_b, e_d;
    int idx;
    if (r) begin
      {m_pb, m_pg, m_pbad, m_muted, m_active} = '0;
      m_pd = 4'b0000;
      return;
    end
    e_btn = b && !m_pb;
    e_g   = g && !m_pg;
    e_b   = bd && !m_pbad;
    e_d   = $onehot(d) && (d != m_pd);
    idx = 0;
    for (int i = 0; i < 4; i++) if (d[i]) idx = i;
    m_pb = b; m_pg = g; m_pbad = bd; m_pd = d;
    if (e_btn) m_muted = !m_muted;
    if (m_muted) begin
      m_active = 0;
      return;
    end
    if ((e_b || e_g || e_d) &&
        (!m_active || (e_b ? 2 : e_g ? 1 : 0) >= m_prio)) begin
      m_active = 1;
      m_k = 0;
      if (e_b)      begin m_prio = 2; m_div = 9;       m_dur = 40; end
      else if (e_g) begin m_prio = 1; m_div = 4;       m_dur = 20; end
      else          begin m_prio = 0; m_div = 2 + idx; m_dur = 10; end
    end else if (m_active) begin
      m_k++;
      if (m_k >= m_dur) m_active = 0;
    end
  endtask

  function automatic int model_out();
    int amp;
    if (!m_active) return 0;
    amp = 'hC0;
`ifdef SOUND_ENVELOPE_EN
    amp = amp - m_k / ENV;
    if (amp < 0) amp = 0;
`endif
    return ((m_k / m_div) % 2 == 0) ? amp : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input bit r, b, g, bd, input bit [3:0] d);
    @(negedge tb_clk);
    rst = r; button_i = b; goodColl_i = g; badColl_i = bd; direction_i = d;
    @(posedge tb_clk);
    #1;
    model_step(r, b, g, bd, d);
    check("model_sound", soundOut, model_out());
    check("model_busy", busy_o, m_active);
    check("model_muted", muted_o, m_muted);
  endtask

  typedef struct {
    bit r, b, g, bd;
    bit [3:0] d;
    bit [7:0] eo;
    bit eb, em;
  } vec_t;
  vec_t tbl[17];

  initial begin
    int len;
    bit [3:0] dv;
    bit rr, bb, gg, bd;

    tbl[0]  = '{1, 0, 1, 0, 4'b0000, 8'h00, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 4'b0010, 8'h00, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 4'b0000, 8'h00, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 4'b0000, 8'hC0, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 4'b0000, 8'hC0, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 4'b0000, 8'hC0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 4'b0000, 8'hC0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 4'b0000, 8'h00, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 4'b0000, 8'h00, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 4'b0000, 8'hC0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 4'b0001, 8'hC0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 4'b0000, 8'h00, 0, 1};
    tbl[12] = '{0, 0, 1, 0, 4'b0000, 8'h00, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 4'b0000, 8'h00, 0, 1};
    tbl[14] = '{0, 1, 0, 0, 4'b0000, 8'h00, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 4'b0100, 8'hC0, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 4'b0011, 8'hC0, 1, 0};

    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].r, tbl[i].b, tbl[i].g, tbl[i].bd, tbl[i].d);
      check($sformatf("tbl%0d_sound", i), soundOut, tbl[i].eo);
      check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].eb);
      check($sformatf("tbl%0d_muted", i), muted_o, tbl[i].em);
    end
    repeat (15) tick(0, 0, 0, 0, 4'b0000);
    check("idle_after_table", busy_o, 0);

    // good pulse: 20 busy cycles, half-period 4
    tick(0, 0, 1, 0, 4'b0000);
    len = busy_o ? 1 : 0;
    for (int k = 1; k < 200 && busy_o; k++) begin
      tick(0, 0, 0, 0, 4'b0000);
      if (k == 4) check("good_k4_low", soundOut, 0);
      if (k == 8) check("good_k8_high", soundOut != 0, 1);
      if (busy_o) len++;
    end
    check("good_len", len, 20);
    check("good_end_sound", soundOut, 0);

    // good, then bad 5 cycles later: restart at period 18, direction ignored mid-bad
    tick(0, 0, 1, 0, 4'b0000);
    repeat (4) tick(0, 0, 0, 0, 4'b0000);
    tick(0, 0, 0, 1, 4'b0000);
    check("bad_start_sound", soundOut, 8'hC0);
    len = busy_o ? 1 : 0;
    for (int k = 1; k < 200 && busy_o; k++) begin
      tick(0, 0, 0, 0, (k == 10) ? 4'b0001 : 4'b0000);
      if (k == 9)  check("bad_k9_low", soundOut, 0);
      if (k == 18) check("bad_k18_high", soundOut != 0, 1);
      if (busy_o) len++;
    end
    check("bad_len", len, 40);

    // direction 0001 then 0100: restart at half-period 4 for 10 cycles
    tick(0, 0, 0, 0, 4'b0001);
    tick(0, 0, 0, 0, 4'b0001);
    tick(0, 0, 0, 0, 4'b0100);
    len = busy_o ? 1 : 0;
    for (int k = 1; k < 200 && busy_o; k++) begin
      tick(0, 0, 0, 0, 4'b0100);
      if (k == 4) check("dir_k4_low", soundOut, 0);
      if (busy_o) len++;
    end
    check("dir_len", len, 10);
    tick(0, 0, 0, 0, 4'b0011);
    check("dir_multihot_busy", busy_o, 0);
    tick(0, 0, 0, 0, 4'b0000);

    // mute mid-tone, ignored event, unmute and replay
    tick(0, 0, 1, 0, 4'b0000);
    repeat (3) tick(0, 0, 0, 0, 4'b0000);
    tick(0, 1, 0, 0, 4'b0000);
    check("mute_on", muted_o, 1);
    check("mute_sound", soundOut, 0);
    check("mute_busy", busy_o, 0);
    tick(0, 0, 1, 0, 4'b0000);
    check("muted_ignore", busy_o, 0);
    tick(0, 1, 0, 0, 4'b0000);
    check("mute_off", muted_o, 0);
    tick(0, 0, 0, 0, 4'b0000);
    tick(0, 0, 1, 0, 4'b0000);
    check("unmuted_play", busy_o, 1);

    // simultaneous good+bad picks bad; then reset mid-play
    repeat (25) tick(0, 0, 0, 0, 4'b0000);
    tick(0, 0, 1, 1, 4'b0000);
    for (int k = 1; k <= 9; k++) tick(0, 0, 0, 0, 4'b0000);
    check("both_bad_k9_low", soundOut, 0);
    check("both_bad_busy", busy_o, 1);
    tick(1, 0, 0, 0, 4'b0000);
    check("rst_sound", soundOut, 0);
    check("rst_busy", busy_o, 0);
    tick(0, 0, 0, 0, 4'b0000);

    // random run against the model
    {rr, bb, gg, bd} = '0;
    dv = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) bb = !bb;
      if ($urandom_range(0, 11) == 0) gg = !gg;
      if ($urandom_range(0, 17) == 0) bd = !bd;
      if ($urandom_range(0, 14) == 0) dv = 4'($urandom_range(0, 15));
      tick(rr, bb, gg, bd, dv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
